uart_rx_frame: RTL



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_bit_timer.sv | 38 +++
 rtl/uart_rx_frame.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line-rate constants and parity mode.
// The transmitter imports the same package so both ends agree on frame format.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE,
        ST_BREAK
    } rx_state_e;

    localparam int CLKS_PER_BIT_9600_50M = 5208;
    localparam int FRAME_DATA_BITS       = 8;

    typedef enum logic {
        PARITY_EVEN,
        PARITY_ODD
    } parity_mode_e;

    localparam parity_mode_e PARITY_MODE = PARITY_EVEN;

    // Parity bit the transmitter appends for a given data byte.
    function automatic logic parity_of(input logic [FRAME_DATA_BITS-1:0] d);
        return (PARITY_MODE == PARITY_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-time counter for the UART receiver: counts while enabled and pulses tick
// at the end of a half or full bit period, restarting from zero on tick or clear.
module uart_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int HALF_BIT     = 8,
    parameter int CNT_W        = 13
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    input  logic half_sel,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit;

    always_comb begin
        limit = half_sel ? CNT_W'(HALF_BIT - 1) : CNT_W'(CLKS_PER_BIT - 1);
        tick  = en && (cnt_q == limit);
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver for 8 data bits, even parity, one stop bit. Delivers each byte
// with a one-cycle rx_valid pulse plus parity and framing status.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_50M,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int CNT_W        = 13
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    logic       sync1_q, sync2_q, rxs;
    rx_state_e  state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] sh_q, sh_d;
    logic       p_err_q, p_err_d;
    logic       f_err_q, f_err_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;
    logic       tick, tmr_clr, tmr_en, tmr_half;

    assign rxs = sync2_q;

    uart_rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .HALF_BIT    (HALF_BIT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .half_sel(tmr_half),
        .tick    (tick)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sh_d         = sh_q;
        p_err_d      = p_err_q;
        f_err_d      = f_err_q;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        rx_valid_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (tick) begin
                    if (!rxs) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    sh_d = {rxs, sh_q[7:1]};
                    if (idx_q == 3'(FRAME_DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    p_err_d = rxs ^ parity_of(sh_q);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    f_err_d = ~rxs;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rx_data_d    = sh_q;
                parity_err_d = p_err_q;
                frame_err_d  = f_err_q;
                rx_valid_d   = 1'b1;
                state_d      = f_err_q ? ST_BREAK : ST_IDLE;
            end
            ST_BREAK: begin
                // Hold off until the line returns high so a stuck-low line is one event.
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        tmr_clr  = (state_d != state_q);
        tmr_en   = (state_q != ST_IDLE);
        tmr_half = (state_q == ST_START);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            sh_q         <= '0;
            p_err_q      <= 1'b0;
            f_err_q      <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= rx_line;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            idx_q        <= idx_d;
            sh_q         <= sh_d;
            p_err_q      <= p_err_d;
            f_err_q      <= f_err_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
